// File: rtl/img_data_unpkt.sv
// Image-over-UDP depacketiser: parses the frame header (magic word + H/V size),
// then turns byte pairs into RGB565 pixels with x/y coordinates and per-packet length checks.
module img_data_unpkt #(
  parameter logic [31:0] IMG_FRAME_HEAD = 32'hf05aa50f,
  parameter logic [15:0] MAX_H_PIXEL    = 16'd1280,
  parameter logic [15:0] MAX_V_PIXEL    = 16'd720
) (
  input  logic        eth_rx_clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  output logic [15:0] img_h_pixel,
  output logic [15:0] img_v_pixel,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, HEAD, SIZE, DATA, SKIP} state_t;

  state_t      state, state_nxt;
  logic [15:0] byte_cnt, byte_cnt_nxt;
  logic [15:0] sz_h, sz_h_nxt;
  logic [7:0]  sz_vh, sz_vh_nxt;
  logic [7:0]  pix_hi, pix_hi_nxt;
  logic [15:0] col, col_nxt, row, row_nxt;
  logic        first_pkt, first_pkt_nxt;
  logic        done_flag, done_flag_nxt;
  logic [15:0] img_h_nxt, img_v_nxt;
  logic [15:0] pix_data_nxt, pix_x_nxt, pix_y_nxt;
  logic        pix_valid_nxt, start_nxt, fdone_nxt, err_nxt;

  logic [7:0]  head_byte;
  logic [15:0] size_v;
  logic        size_ok, hdr_last;
  logic [16:0] exp_len, rx_len;

  always_comb begin
    case (byte_cnt[1:0])
      2'd1:    head_byte = IMG_FRAME_HEAD[23:16];
      2'd2:    head_byte = IMG_FRAME_HEAD[15:8];
      default: head_byte = IMG_FRAME_HEAD[7:0];
    endcase
  end

  assign size_v   = {sz_vh, rec_data};
  assign size_ok  = (sz_h != 16'd0) && (sz_h <= MAX_H_PIXEL) &&
                    (size_v != 16'd0) && (size_v <= MAX_V_PIXEL);
  assign hdr_last = rec_en && (byte_cnt == 16'd7);
  // Header packet carries 8 header bytes ahead of the first row.
  assign exp_len  = {img_h_pixel, 1'b0} + (first_pkt ? 17'd8 : 17'd0);
  // Length includes a byte arriving together with rec_pkt_done.
  assign rx_len   = {1'b0, byte_cnt} + {16'd0, rec_en};

  always_comb begin
    state_nxt     = state;
    if (rec_pkt_done)
      byte_cnt_nxt = 16'd0;
    else if (rec_en && byte_cnt != 16'hffff)
      byte_cnt_nxt = byte_cnt + 16'd1;
    else
      byte_cnt_nxt = byte_cnt;
    sz_h_nxt      = sz_h;
    sz_vh_nxt     = sz_vh;
    pix_hi_nxt    = pix_hi;
    col_nxt       = col;
    row_nxt       = row;
    first_pkt_nxt = first_pkt;
    done_flag_nxt = done_flag;
    img_h_nxt     = img_h_pixel;
    img_v_nxt     = img_v_pixel;
    pix_valid_nxt = 1'b0;
    pix_data_nxt  = pix_data;
    pix_x_nxt     = pix_x;
    pix_y_nxt     = pix_y;
    start_nxt     = 1'b0;
    fdone_nxt     = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (rec_en) begin
          if (rec_data == IMG_FRAME_HEAD[31:24]) begin
            if (rec_pkt_done) err_nxt = 1'b1;
            else              state_nxt = HEAD;
          end else if (!rec_pkt_done) begin
            state_nxt = SKIP;
          end
        end
      end

      HEAD: begin
        // A wrong magic byte is just foreign traffic, not a protocol error.
        if (rec_en && rec_data != head_byte) begin
          state_nxt = rec_pkt_done ? IDLE : SKIP;
        end else begin
          if (rec_en && byte_cnt == 16'd3) state_nxt = SIZE;
          if (rec_pkt_done) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      SIZE: begin
        if (rec_en) begin
          case (byte_cnt[1:0])
            2'd0:    sz_h_nxt[15:8] = rec_data;
            2'd1:    sz_h_nxt[7:0]  = rec_data;
            2'd2:    sz_vh_nxt      = rec_data;
            default: ;
          endcase
        end
        if (hdr_last) begin
          // A header-only packet can never satisfy the 2*H+8 length check.
          if (size_ok && !rec_pkt_done) begin
            img_h_nxt     = sz_h;
            img_v_nxt     = size_v;
            start_nxt     = 1'b1;
            pix_x_nxt     = 16'd0;
            pix_y_nxt     = 16'd0;
            col_nxt       = 16'd0;
            row_nxt       = 16'd0;
            first_pkt_nxt = 1'b1;
            done_flag_nxt = 1'b0;
            state_nxt     = DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = rec_pkt_done ? IDLE : SKIP;
          end
        end else if (rec_pkt_done) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      DATA: begin
        if (rec_en && !byte_cnt[0]) pix_hi_nxt = rec_data;
        if (rec_en && byte_cnt[0] && ({1'b0, byte_cnt} < exp_len)) begin
          pix_valid_nxt = 1'b1;
          pix_data_nxt  = {pix_hi, rec_data};
          pix_x_nxt     = col;
          pix_y_nxt     = row;
          if (col == img_h_pixel - 16'd1) begin
            col_nxt = 16'd0;
            row_nxt = row + 16'd1;
            if (row == img_v_pixel - 16'd1) begin
              fdone_nxt     = 1'b1;
              done_flag_nxt = 1'b1;
            end
          end else begin
            col_nxt = col + 16'd1;
          end
        end
        if (rec_pkt_done) begin
          first_pkt_nxt = 1'b0;
          if (rx_len != exp_len) begin
            err_nxt   = !fdone_nxt;
            state_nxt = IDLE;
          end else if (done_flag || fdone_nxt) begin
            state_nxt = IDLE;
          end
        end
      end

      SKIP: begin
        if (rec_pkt_done) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge eth_rx_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge eth_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      sz_h        <= '0;
      sz_vh       <= '0;
      pix_hi      <= '0;
      col         <= '0;
      row         <= '0;
      first_pkt   <= 1'b0;
      done_flag   <= 1'b0;
      img_h_pixel <= '0;
      img_v_pixel <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      byte_cnt    <= byte_cnt_nxt;
      sz_h        <= sz_h_nxt;
      sz_vh       <= sz_vh_nxt;
      pix_hi      <= pix_hi_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      first_pkt   <= first_pkt_nxt;
      done_flag   <= done_flag_nxt;
      img_h_pixel <= img_h_nxt;
      img_v_pixel <= img_v_nxt;
      frame_start <= start_nxt;
      pix_valid   <= pix_valid_nxt;
      pix_data    <= pix_data_nxt;
      pix_x       <= pix_x_nxt;
      pix_y       <= pix_y_nxt;
      frame_done  <= fdone_nxt;
      frame_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_img_data_unpkt.sv
// Scoreboard bench for img_data_unpkt: stimulus queues expected events,
// a negedge monitor pops and compares every start/pixel/error event.
module tb_img_data_unpkt;

  logic        eth_rx_clk = 1'b0;
  logic        rst_n;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] img_h_pixel, img_v_pixel;
  logic        frame_start, pix_valid, frame_done, frame_err;
  logic [15:0] pix_data, pix_x, pix_y;

  img_data_unpkt dut (
    .eth_rx_clk  (eth_rx_clk),
    .rst_n       (rst_n),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .img_h_pixel (img_h_pixel),
    .img_v_pixel (img_v_pixel),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 eth_rx_clk = ~eth_rx_clk;

  typedef logic [7:0] bq_t[$];
  // flags = {pix_valid, frame_start, frame_err, frame_done}
  typedef struct {
    logic [3:0]  flags;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
  } ev_t;

  ev_t exq[$];
  int  checks = 0;
  int  passed = 0;
  bq_t pk;

  function automatic bq_t hdr(input logic [15:0] h, input logic [15:0] v);
    bq_t q;
    q = '{8'hf0, 8'h5a, 8'ha5, 8'h0f, h[15:8], h[7:0], v[15:8], v[7:0]};
    return q;
  endfunction

  function automatic bq_t cat(input bq_t x, input bq_t y);
    bq_t q;
    q = x;
    foreach (y[i]) q.push_back(y[i]);
    return q;
  endfunction

  task automatic exp_start(input logic [15:0] h, input logic [15:0] v);
    ev_t e;
    e.flags = 4'b0100; e.a = h; e.b = v; e.c = 16'd0;
    exq.push_back(e);
  endtask

  task automatic exp_err();
    ev_t e;
    e.flags = 4'b0010; e.a = 16'd0; e.b = 16'd0; e.c = 16'd0;
    exq.push_back(e);
  endtask

  task automatic exp_pix(input logic [15:0] d, input logic [15:0] x,
                         input logic [15:0] y, input bit done);
    ev_t e;
    e.flags = {3'b100, done}; e.a = d; e.b = x; e.c = y;
    exq.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s act=%h req=%h", name, act, req);
  endtask

  // Sends bytes back to back; rec_pkt_done rides the last byte or follows it.
  task automatic send(input bq_t b, input bit done_with_last, input bit end_pkt);
    foreach (b[i]) begin
      @(posedge eth_rx_clk); #1;
      rec_en       = 1'b1;
      rec_data     = b[i];
      rec_pkt_done = end_pkt && done_with_last && (i == b.size() - 1);
    end
    @(posedge eth_rx_clk); #1;
    rec_en       = 1'b0;
    rec_pkt_done = end_pkt && !done_with_last;
    @(posedge eth_rx_clk); #1;
    rec_pkt_done = 1'b0;
    repeat (2) @(posedge eth_rx_clk);
    #1;
  endtask

  // H=4, V=2 frame in a 16-byte header packet plus an 8-byte row packet.
  task automatic frame_4x2();
    exp_start(16'd4, 16'd2);
    exp_pix(16'h1122, 0, 0, 0); exp_pix(16'h3344, 1, 0, 0);
    exp_pix(16'h5566, 2, 0, 0); exp_pix(16'h7788, 3, 0, 0);
    exp_pix(16'h99aa, 0, 1, 0); exp_pix(16'hbbcc, 1, 1, 0);
    exp_pix(16'hddee, 2, 1, 0); exp_pix(16'hf001, 3, 1, 1);
    pk = cat(hdr(16'd4, 16'd2), '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    send(pk, 1'b0, 1'b1);
    pk = '{8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hf0, 8'h01};
    send(pk, 1'b0, 1'b1);
  endtask

  ev_t        mon_e;
  logic [3:0] mon_f;
  always @(negedge eth_rx_clk) begin
    if (rst_n) begin
      mon_f = {pix_valid, frame_start, frame_err, frame_done};
      if (mon_f != 4'b0000) begin
        checks++;
        if (exq.size() == 0) begin
          $display("FAIL unexpected_event act=%b data=%h x=%0d y=%0d req=none",
                   mon_f, pix_data, pix_x, pix_y);
        end else begin
          mon_e = exq.pop_front();
          if (mon_f != mon_e.flags)
            $display("FAIL event_flags act=%b req=%b", mon_f, mon_e.flags);
          else if (mon_f[3] && {pix_data, pix_x, pix_y} != {mon_e.a, mon_e.b, mon_e.c})
            $display("FAIL pixel act=%h/%0d/%0d req=%h/%0d/%0d",
                     pix_data, pix_x, pix_y, mon_e.a, mon_e.b, mon_e.c);
          else if (mon_f[2] && {img_h_pixel, img_v_pixel} != {mon_e.a, mon_e.b})
            $display("FAIL frame_start_size act=%0dx%0d req=%0dx%0d",
                     img_h_pixel, img_v_pixel, mon_e.a, mon_e.b);
          else
            passed++;
        end
      end
    end
  end

  logic [15:0] bad_h[4] = '{16'd0, 16'd1281, 16'd4, 16'd4};
  logic [15:0] bad_v[4] = '{16'd2, 16'd2,    16'd0, 16'd721};

  initial begin
    rst_n = 1'b0; rec_en = 1'b0; rec_data = 8'h00; rec_pkt_done = 1'b0;
    repeat (3) @(posedge eth_rx_clk);
    #1;
    check("reset_outputs",
          {4'd0, img_h_pixel, img_v_pixel, frame_start, pix_valid, frame_done, frame_err, pix_data},
          64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge eth_rx_clk);
    #1;

    // Basic 4x2 frame
    frame_4x2();
    check("img_size_4x2", {32'd0, img_h_pixel, img_v_pixel}, {32'd0, 16'd4, 16'd2});

    // Corrupt magic is skipped silently; next header (2x1, done on last byte) accepted
    pk = '{8'hf0, 8'h5a, 8'h00, 8'h0f, 8'h00, 8'h04, 8'h00, 8'h02, 8'h12, 8'h34};
    send(pk, 1'b1, 1'b1);
    exp_start(16'd2, 16'd1);
    exp_pix(16'ha1b2, 0, 0, 0);
    exp_pix(16'hc3d4, 1, 0, 1);
    pk = cat(hdr(16'd2, 16'd1), '{8'ha1, 8'hb2, 8'hc3, 8'hd4});
    send(pk, 1'b1, 1'b1);

    // Out-of-range sizes
    for (int i = 0; i < 4; i++) begin
      exp_err();
      pk = cat(hdr(bad_h[i], bad_v[i]), '{8'h01, 8'h02, 8'h03, 8'h04});
      send(pk, 1'b1, 1'b1);
    end
    check("img_size_hold", {32'd0, img_h_pixel, img_v_pixel}, {32'd0, 16'd2, 16'd1});

    // Short second packet: 3 pixels then length error
    exp_start(16'd4, 16'd2);
    exp_pix(16'h1122, 0, 0, 0); exp_pix(16'h3344, 1, 0, 0);
    exp_pix(16'h5566, 2, 0, 0); exp_pix(16'h7788, 3, 0, 0);
    exp_pix(16'h99aa, 0, 1, 0); exp_pix(16'hbbcc, 1, 1, 0);
    exp_pix(16'hddee, 2, 1, 0);
    exp_err();
    pk = cat(hdr(16'd4, 16'd2), '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    send(pk, 1'b0, 1'b1);
    pk = '{8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    send(pk, 1'b0, 1'b1);
    frame_4x2();

    // Reset mid-packet with a partial pixel pending
    exp_start(16'd4, 16'd2);
    exp_pix(16'h1122, 0, 0, 0); exp_pix(16'h3344, 1, 0, 0);
    pk = cat(hdr(16'd4, 16'd2), '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    send(pk, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midpkt_reset_outputs",
          {4'd0, img_h_pixel, img_v_pixel, frame_start, pix_valid, frame_done, frame_err, pix_data},
          64'd0);
    check("midpkt_reset_xy", {32'd0, pix_x, pix_y}, 64'd0);
    @(posedge eth_rx_clk); #1;
    rst_n = 1'b1;
    pk = '{8'h66, 8'h77, 8'h88};
    send(pk, 1'b1, 1'b1);
    frame_4x2();

    repeat (10) @(posedge eth_rx_clk);
    #1;
    check("scoreboard_drained", 64'(exq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule
